// File: rtl/tmboc_trk_pkg.sv
// tmboc_trk_pkg: shared FSM encoding, PRN length and default widths for the TMBOC tracking correlator.
package tmboc_trk_pkg;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;
    localparam int PRN_LEN          = 4092;
    localparam int DEF_SAMPLE_WIDTH = 4;
    localparam int DEF_ACC_WIDTH    = 24;
    localparam int DEF_SPACING      = 2;
    localparam int DEF_CNT_WIDTH    = 16;
endpackage

// File: rtl/tmboc_corr_arm.sv
// tmboc_corr_arm: one I+Q multiply-accumulate arm; ACC_SAT_EN selects saturating instead of wrapping sums.
module tmboc_corr_arm
    import tmboc_trk_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int ACC_WIDTH    = DEF_ACC_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           add,
    input  logic                           restart,
    input  logic                           close,
    input  logic                           code,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_i,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_q,
    output logic signed [ACC_WIDTH-1:0]    sum_i,
    output logic signed [ACC_WIDTH-1:0]    sum_q,
    output logic                           sat
);
`ifdef ACC_SAT_EN
    localparam logic signed [ACC_WIDTH:0] SAT_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = -SAT_MAX;
`endif
    logic signed [ACC_WIDTH-1:0] acc_i, acc_q;
    logic [ACC_WIDTH:0] r_i, r_q;
    // Result is {clamped, sum}; the clamp flag is only ever set in the saturating build.
    function automatic logic [ACC_WIDTH:0] mac(input logic signed [ACC_WIDTH-1:0] base,
                                               input logic signed [SAMPLE_WIDTH-1:0] s,
                                               input logic c);
        logic signed [ACC_WIDTH-1:0] ext;
`ifdef ACC_SAT_EN
        logic signed [ACC_WIDTH:0] wide;
`endif
        ext = {{(ACC_WIDTH-SAMPLE_WIDTH){s[SAMPLE_WIDTH-1]}}, s};
`ifdef ACC_SAT_EN
        wide = {base[ACC_WIDTH-1], base} + (c ? -{ext[ACC_WIDTH-1], ext} : {ext[ACC_WIDTH-1], ext});
        return wide > SAT_MAX ? {1'b1, SAT_MAX[ACC_WIDTH-1:0]} :
               wide < SAT_MIN ? {1'b1, SAT_MIN[ACC_WIDTH-1:0]} : {1'b0, wide[ACC_WIDTH-1:0]};
`else
        return {1'b0, base + (c ? -ext : ext)};
`endif
    endfunction
    assign r_i   = mac(restart ? '0 : acc_i, sample_i, code);
    assign r_q   = mac(restart ? '0 : acc_q, sample_q, code);
    assign sum_i = r_i[ACC_WIDTH-1:0];
    assign sum_q = r_q[ACC_WIDTH-1:0];
    assign sat   = add && (r_i[ACC_WIDTH] || r_q[ACC_WIDTH]);
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            acc_i <= '0;
            acc_q <= '0;
        end else if (add) begin
            acc_i <= close ? '0 : sum_i;
            acc_q <= close ? '0 : sum_q;
        end
    end
endmodule

// File: rtl/tmboc_epoch_correlator.sv
// tmboc_epoch_correlator: Early/Prompt/Late I/Q correlation over one PRN epoch with a valid/ready dump.
// Optional macro ACC_SAT_EN: saturating accumulators, a saturated epoch also flags tx_dump_ovr.
module tmboc_epoch_correlator
    import tmboc_trk_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int ACC_WIDTH    = DEF_ACC_WIDTH,
    parameter int SPACING      = DEF_SPACING,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
    input  logic                           rx_clk,
    input  logic                           rx_rst,
    input  logic                           rx_enable,
    input  logic                           rx_sample_vld,
    input  logic signed [SAMPLE_WIDTH-1:0] rx_sample_i,
    input  logic signed [SAMPLE_WIDTH-1:0] rx_sample_q,
    input  logic                           rx_loc_code,
    input  logic                           rx_prn_sop,
    input  logic                           rx_prn_eop,
    output logic                           tx_dump_vld,
    input  logic                           tx_dump_rdy,
    output logic signed [ACC_WIDTH-1:0]    tx_ie,
    output logic signed [ACC_WIDTH-1:0]    tx_qe,
    output logic signed [ACC_WIDTH-1:0]    tx_ip,
    output logic signed [ACC_WIDTH-1:0]    tx_qp,
    output logic signed [ACC_WIDTH-1:0]    tx_il,
    output logic signed [ACC_WIDTH-1:0]    tx_ql,
    output logic                           tx_dump_ovr,
    output logic                           tx_sync_err,
    output logic [CNT_WIDTH-1:0]           tx_epoch_cnt
);
    logic [0:0] state;
    logic open, sat_ep;
    logic [2*SPACING-1:0] taps;
    logic [SPACING-1:0] sop_sr, eop_sr;
    logic [2*SPACING:0] taps_n;
    logic [SPACING:0] sop_n, eop_n;
    logic sop_a, eop_a, add, restart, close, sync, accept;
    logic signed [ACC_WIDTH-1:0] sum_i [3];
    logic signed [ACC_WIDTH-1:0] sum_q [3];
    logic [2:0] sat;
    // Taps and framing include the current strobe so the sample meets its aligned code in the same cycle.
    assign taps_n  = {taps, rx_loc_code};
    assign sop_n   = {sop_sr, rx_prn_sop};
    assign eop_n   = {eop_sr, rx_prn_eop};
    assign sop_a   = sop_n[SPACING];
    assign eop_a   = eop_n[SPACING];
    assign add     = rx_enable && rx_sample_vld && (sop_a || (state == ST_ACCUM && open));
    assign restart = sop_a && !eop_a;
    assign close   = add && eop_a;
    assign sync    = add && open && restart;
    assign accept  = tx_dump_vld && tx_dump_rdy;
    for (genvar g = 0; g < 3; g++) begin : g_arm
        tmboc_corr_arm #(.SAMPLE_WIDTH(SAMPLE_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_arm (
            .clk(rx_clk), .rst(rx_rst), .flush(!rx_enable), .add(add), .restart(restart),
            .close(close), .code(taps_n[g*SPACING]), .sample_i(rx_sample_i),
            .sample_q(rx_sample_q), .sum_i(sum_i[g]), .sum_q(sum_q[g]), .sat(sat[g])
        );
    end
    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            state        <= ST_IDLE;
            open         <= 1'b0;
            sat_ep       <= 1'b0;
            taps         <= '0;
            sop_sr       <= '0;
            eop_sr       <= '0;
            tx_dump_vld  <= 1'b0;
            tx_ie        <= '0;
            tx_qe        <= '0;
            tx_ip        <= '0;
            tx_qp        <= '0;
            tx_il        <= '0;
            tx_ql        <= '0;
            tx_dump_ovr  <= 1'b0;
            tx_sync_err  <= 1'b0;
            tx_epoch_cnt <= '0;
        end else begin
            tx_sync_err <= sync;
            if (rx_sample_vld) begin
                taps   <= taps_n[2*SPACING-1:0];
                sop_sr <= sop_n[SPACING-1:0];
                eop_sr <= eop_n[SPACING-1:0];
            end
            state  <= !rx_enable ? ST_IDLE : add ? ST_ACCUM : state;
            open   <= rx_enable && (add ? !eop_a : open);
            sat_ep <= rx_enable && (add ? !close && ((!restart && sat_ep) || |sat) : sat_ep);
            if (close) begin
                tx_ie        <= sum_i[0];
                tx_qe        <= sum_q[0];
                tx_ip        <= sum_i[1];
                tx_qp        <= sum_q[1];
                tx_il        <= sum_i[2];
                tx_ql        <= sum_q[2];
                tx_dump_vld  <= 1'b1;
                tx_epoch_cnt <= tx_epoch_cnt + CNT_WIDTH'(1);
                tx_dump_ovr  <= tx_dump_ovr || (tx_dump_vld && !tx_dump_rdy) || sat_ep || |sat;
            end else if (accept) begin
                tx_dump_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tmboc_epoch_correlator.sv
// tb_tmboc_epoch_correlator: scoreboard bench for the epoch correlator (main instance plus a 12-bit accumulator instance).
module tb_tmboc_epoch_correlator;
    import tmboc_trk_pkg::*;
    localparam int SW = 4;
    localparam int AW = 24;
    localparam int S  = 2;
    localparam int CW = 16;
    typedef struct {int ie, qe, ip, qp, il, ql, cnt;} exp_t;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, en, en12, vld, code, sop, eop, rdy;
    logic one = 1'b1;
    logic signed [SW-1:0] si, sq;
    logic dvld, ovr, serr;
    logic signed [AW-1:0] ie, qe, ip, qp, il, ql;
    logic [CW-1:0] cnt;
    logic dvld12, ovr12, serr12;
    logic signed [11:0] ie12, qe12, ip12, qp12, il12, ql12;
    logic [CW-1:0] cnt12;
    int n_assert = 0, n_fail = 0, n_sync = 0, m_cnt = 0, main_en = 1;
    int m_sum [6];
    bit m_open = 0;
    logic ch[$], sh[$], eh[$];
    exp_t exp_q[$];

    tmboc_epoch_correlator #(.SAMPLE_WIDTH(SW), .ACC_WIDTH(AW), .SPACING(S), .CNT_WIDTH(CW)) dut (
        .rx_clk(clk), .rx_rst(rst), .rx_enable(en), .rx_sample_vld(vld), .rx_sample_i(si),
        .rx_sample_q(sq), .rx_loc_code(code), .rx_prn_sop(sop), .rx_prn_eop(eop),
        .tx_dump_vld(dvld), .tx_dump_rdy(rdy), .tx_ie(ie), .tx_qe(qe), .tx_ip(ip), .tx_qp(qp),
        .tx_il(il), .tx_ql(ql), .tx_dump_ovr(ovr), .tx_sync_err(serr), .tx_epoch_cnt(cnt));

    tmboc_epoch_correlator #(.SAMPLE_WIDTH(SW), .ACC_WIDTH(12), .SPACING(S), .CNT_WIDTH(CW)) dut12 (
        .rx_clk(clk), .rx_rst(rst), .rx_enable(en12), .rx_sample_vld(vld), .rx_sample_i(si),
        .rx_sample_q(sq), .rx_loc_code(code), .rx_prn_sop(sop), .rx_prn_eop(eop),
        .tx_dump_vld(dvld12), .tx_dump_rdy(one), .tx_ie(ie12), .tx_qe(qe12), .tx_ip(ip12),
        .tx_qp(qp12), .tx_il(il12), .tx_ql(ql12), .tx_dump_ovr(ovr12), .tx_sync_err(serr12),
        .tx_epoch_cnt(cnt12));

    task automatic check(input string tag, input int act, input int exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int w(input int x);
        logic signed [AW-1:0] t;
        t = x[AW-1:0];
        return int'(t);
    endfunction

    // Reference: sample k meets codes k (E), k-S (P), k-2S (L); framing seen S samples late.
    task automatic model(input bit e, input bit v, input bit c, input bit so, input bit eo,
                         input int i, input int q);
        int n;
        bit ce, cp, cl, sa, ea;
        if (!e) begin
            m_open = 0;
            m_sum = '{default: 0};
        end
        if (!v) return;
        ch.push_back(c);
        sh.push_back(so);
        eh.push_back(eo);
        if (!e) return;
        n  = ch.size();
        ce = ch[n-1];
        cp = (n > S) ? ch[n-1-S] : 1'b0;
        cl = (n > 2*S) ? ch[n-1-2*S] : 1'b0;
        sa = (n > S) ? sh[n-1-S] : 1'b0;
        ea = (n > S) ? eh[n-1-S] : 1'b0;
        if (!(sa || m_open)) return;
        if (sa && !(m_open && ea)) m_sum = '{default: 0};
        m_sum[0] += ce ? -i : i;
        m_sum[1] += ce ? -q : q;
        m_sum[2] += cp ? -i : i;
        m_sum[3] += cp ? -q : q;
        m_sum[4] += cl ? -i : i;
        m_sum[5] += cl ? -q : q;
        if (ea) begin
            m_cnt = (m_cnt + 1) % 65536;
            exp_q.push_back('{w(m_sum[0]), w(m_sum[1]), w(m_sum[2]), w(m_sum[3]),
                              w(m_sum[4]), w(m_sum[5]), m_cnt});
            m_sum = '{default: 0};
            m_open = 0;
        end else begin
            m_open = 1;
        end
    endtask

    task automatic drive(input bit e, input bit v, input bit c, input bit so, input bit eo,
                         input int i, input int q);
        @(posedge clk);
        #1;
        en = e; vld = v; code = c; sop = so; eop = eo;
        si = SW'(i); sq = SW'(q);
        model(e, v, c, so, eo, i, q);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(main_en != 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    // mode 0: constant code 0, 1: alternating code, 2: random code and samples
    task automatic epoch(input int len, input int extra, input int tail, input int mode,
                         input int i, input int q, input int rdy_at);
        bit c;
        int ii, qq;
        for (int j = 0; j < len + tail; j++) begin
            c  = mode == 0 ? 1'b0 : mode == 1 ? j[0] : 1'($urandom_range(0, 1));
            ii = mode == 2 ? int'($urandom_range(0, 15)) - 8 : i;
            qq = mode == 2 ? int'($urandom_range(0, 15)) - 8 : q;
            drive(main_en != 0, 1'b1, c, j == 0 || j == extra, j == len - 1, ii, qq);
            if (j == rdy_at) rdy = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (serr) n_sync++;
        if (!rst && dvld && rdy) begin
            if (exp_q.size() == 0) check("dump_expected", exp_q.size(), 1);
            else begin
                e = exp_q.pop_front();
                check("sb_ie", ie, e.ie);
                check("sb_qe", qe, e.qe);
                check("sb_ip", ip, e.ip);
                check("sb_qp", qp, e.qp);
                check("sb_il", il, e.il);
                check("sb_ql", ql, e.ql);
                check("sb_cnt", int'(cnt), e.cnt);
            end
        end
    end

    initial begin
        int s0;
        logic signed [11:0] wrap12;
        exp_t stale;
        rst = 1; en = 0; en12 = 0; vld = 0; code = 0; sop = 0; eop = 0; rdy = 1; si = 0; sq = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vld", dvld, 0);
        check("rst_ip", ip, 0);
        check("rst_cnt", int'(cnt), 0);
        check("rst_ovr", ovr, 0);
        check("rst_sync", serr, 0);
        rst = 0;
        idle(3);
        // constant samples, code 0
        epoch(PRN_LEN, -1, S, 0, 3, -2, -1);
        check("t1_vld_before", dvld, 0);
        idle(1);
        check("t1_vld", dvld, 1);
        check("t1_ip", ip, 12276);
        check("t1_qp", qp, -8184);
        check("t1_cnt", int'(cnt), 1);
        idle(2);
        check("t1_vld_drop", dvld, 0);
        // alternating code
        epoch(PRN_LEN, -1, S, 1, 1, 0, -1);
        idle(1);
        check("t2_ip", ip, 0);
        idle(2);
        epoch(PRN_LEN, -1, S, 2, 0, 0, -1);
        idle(2);
        // new dump in the cycle of acceptance is not an overrun
        rdy = 0;
        epoch(PRN_LEN, -1, 0, 2, 0, 0, -1);
        epoch(PRN_LEN, -1, S, 2, 0, 0, PRN_LEN + S - 1);
        idle(1);
        check("t2c_vld", dvld, 1);
        check("t2c_ovr", ovr, 0);
        idle(2);
        // overwrite while stalled
        rdy = 0;
        epoch(PRN_LEN, -1, 0, 2, 0, 0, -1);
        epoch(PRN_LEN, -1, S, 2, 0, 0, -1);
        idle(1);
        check("t3_vld", dvld, 1);
        check("t3_ovr", ovr, 1);
        check("t3_cnt", int'(cnt), m_cnt);
        stale = exp_q.pop_front();
        check("t3_stale_cnt", stale.cnt, m_cnt - 1);
        rdy = 1;
        idle(1);
        check("t3_vld_drop", dvld, 0);
        idle(2);
        // extra SOP mid-epoch
        s0 = n_sync;
        epoch(2000 + PRN_LEN, 2000, S, 2, 0, 0, -1);
        idle(1);
        check("t4_sync_pulses", n_sync - s0, 1);
        check("t4_vld", dvld, 1);
        idle(2);
        // enable drop with a pending dump
        rdy = 0;
        epoch(PRN_LEN, -1, S, 2, 0, 0, -1);
        for (int j = 0; j < 1000; j++)
            drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), j == 0, 1'b0, 5, -3);
        for (int j = 0; j < 6; j++)
            drive(1'b0, 1'b1, 1'b0, j == 1, j == 3, 2, 2);
        check("t5_pending_vld", dvld, 1);
        rdy = 1;
        idle(3);
        epoch(PRN_LEN, -1, S, 2, 0, 0, -1);
        idle(2);
        check("t5_q_empty", exp_q.size(), 0);
        // reset mid-epoch
        rdy = 0;
        epoch(PRN_LEN, -1, S, 2, 0, 0, -1);
        for (int j = 0; j < 500; j++)
            drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), j == 0, 1'b0, -4, 7);
        rst = 1;
        @(posedge clk);
        #1;
        check("rst2_vld", dvld, 0);
        check("rst2_ie", ie, 0);
        check("rst2_qe", qe, 0);
        check("rst2_ip", ip, 0);
        check("rst2_qp", qp, 0);
        check("rst2_il", il, 0);
        check("rst2_ql", ql, 0);
        check("rst2_ovr", ovr, 0);
        check("rst2_sync", serr, 0);
        check("rst2_cnt", int'(cnt), 0);
        exp_q.delete(); ch.delete(); sh.delete(); eh.delete();
        m_open = 0; m_cnt = 0; m_sum = '{default: 0};
        vld = 0; rdy = 1; rst = 0;
        idle(3);
        // 12-bit accumulator instance, main instance disabled
        main_en = 0;
        en12 = 1;
        idle(3);
        epoch(PRN_LEN, -1, S, 0, -8, 0, -1);
        idle(1);
        check("t6_vld", dvld12, 1);
`ifdef ACC_SAT_EN
        check("t6_ip", ip12, -2047);
        check("t6_ovr", ovr12, 1);
`else
        wrap12 = 12'(-8 * PRN_LEN);
        check("t6_ip", ip12, int'(wrap12));
        check("t6_ovr", ovr12, 0);
`endif
        check("t6_ie", ie12, ip12);
        check("t6_il", il12, ip12);
        check("t6_qe", qe12, 0);
        check("t6_qp", qp12, 0);
        check("t6_ql", ql12, 0);
        check("t6_cnt", int'(cnt12), 1);
        check("t6_sync", serr12, 0);
        check("t6_main_idle", dvld, 0);
        idle(2);
        check("q_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
